// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler_if
//  Description : Sensor / pre-empt / lamp bundle for the two-approach
//                actuated phase scheduler.
//                master : sensor/pre-empt side (drives requests, sees lamps)
//                slave  : scheduler side (sees requests, drives lamps)
//  Signals     : req_ns, req_we      vehicle presence, level-sensitive
//                preempt, preempt_dir emergency pre-empt and its target
//                                     approach (0 = NS, 1 = WE)
//                LED_NS, LED_WE       lamp codes 100 red / 010 yellow /
//                                     001 green
//                phase                current state code (observability)
//                preempt_ack          pre-empt target approach is green
//  Revision    : 1.0  initial release
// ============================================================================
interface traffic_phase_scheduler_if;
   logic       req_ns;
   logic       req_we;
   logic       preempt;
   logic       preempt_dir;
   logic [2:0] LED_NS;
   logic [2:0] LED_WE;
   logic [2:0] phase;
   logic       preempt_ack;

   modport master (
      output req_ns, req_we, preempt, preempt_dir,
      input  LED_NS, LED_WE, phase, preempt_ack
   );

   modport slave (
      input  req_ns, req_we, preempt, preempt_dir,
      output LED_NS, LED_WE, phase, preempt_ack
   );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_scheduler
//  Description : Demand-actuated green arbitration between the North-South
//                and West-East approaches, with emergency pre-empt. Every
//                green-to-green change passes through YELLOW then ALLRED.
//  Ports       : clk    clock, all state changes on the rising edge
//                rst    synchronous reset, active low
//                sched  slave side of traffic_phase_scheduler_if
//                       (requests/pre-empt in, lamp codes/phase/ack out)
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_phase_scheduler #(
   parameter int unsigned GREEN_MIN = 8,
   parameter int unsigned GREEN_MAX = 15,
   parameter int unsigned YELLOW    = 3,
   parameter int unsigned ALLRED    = 2,
   parameter int unsigned CW        = 5
) (
   input  wire                           clk,
   input  wire                           rst,
   traffic_phase_scheduler_if.slave      sched
);

   // State codes double as the observable phase value.
   localparam logic [2:0] S_NS_G  = 3'd0;
   localparam logic [2:0] S_NS_Y  = 3'd1;
   localparam logic [2:0] S_RED_A = 3'd2;
   localparam logic [2:0] S_WE_G  = 3'd3;
   localparam logic [2:0] S_WE_Y  = 3'd4;
   localparam logic [2:0] S_RED_B = 3'd5;

   localparam logic [2:0] c_LAMP_RED = 3'b100;
   localparam logic [2:0] c_LAMP_YEL = 3'b010;
   localparam logic [2:0] c_LAMP_GRN = 3'b001;

   // Last cycle index of each timed interval.
   localparam logic [CW-1:0] c_GMIN_LAST = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] c_GMAX_LAST = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] c_YEL_LAST  = CW'(YELLOW - 1);
   localparam logic [CW-1:0] c_AR_LAST   = CW'(ALLRED - 1);

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    w_next_state;
   logic [CW-1:0] w_next_cnt;

   // Green-state view, expressed relative to the approach holding green.
   logic w_in_green;
   logic w_own_req;
   logic w_opp_req;
   logic w_own_dir;
   logic w_pre_own;
   logic w_pre_opp;
   logic w_leave_green;

   logic [2:0] w_led_ns;
   logic [2:0] w_led_we;
   logic       w_ack;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_NS_G;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_in_green = (r_state == S_NS_G) || (r_state == S_WE_G);
      w_own_dir  = (r_state == S_WE_G);
      w_own_req  = w_own_dir ? sched.req_we : sched.req_ns;
      w_opp_req  = w_own_dir ? sched.req_ns : sched.req_we;
      w_pre_own  = sched.preempt && (sched.preempt_dir == w_own_dir);
      w_pre_opp  = sched.preempt && (sched.preempt_dir != w_own_dir);

      // Pre-empt for our own approach pins green; pre-empt for the other
      // side forces yellow at once. Otherwise green ends only after the
      // minimum, and only if the other side is waiting and either we have
      // no demand left or the maximum is reached.
      w_leave_green = !w_pre_own &&
                      (w_pre_opp ||
                       ((r_cnt >= c_GMIN_LAST) && w_opp_req &&
                        (!w_own_req || (r_cnt == c_GMAX_LAST))));

      w_next_state = r_state;
      case (r_state)
         S_NS_G:  if (w_leave_green)        w_next_state = S_NS_Y;
         S_WE_G:  if (w_leave_green)        w_next_state = S_WE_Y;
         S_NS_Y:  if (r_cnt == c_YEL_LAST)  w_next_state = S_RED_A;
         S_WE_Y:  if (r_cnt == c_YEL_LAST)  w_next_state = S_RED_B;
         S_RED_A: if (r_cnt == c_AR_LAST)
                     w_next_state = sched.preempt ?
                                    (sched.preempt_dir ? S_WE_G : S_NS_G) :
                                    S_WE_G;
         S_RED_B: if (r_cnt == c_AR_LAST)
                     w_next_state = sched.preempt ?
                                    (sched.preempt_dir ? S_WE_G : S_NS_G) :
                                    S_NS_G;
         default:                           w_next_state = S_NS_G;
      endcase

      // Counter restarts on every state entry (including the recovery from
      // an unused code); in green it parks at GREEN_MAX-1 so a long
      // pre-empt hold cannot wrap it.
      if (w_next_state != r_state) begin
         w_next_cnt = '0;
      end else if (w_in_green && (r_cnt == c_GMAX_LAST)) begin
         w_next_cnt = r_cnt;
      end else begin
         w_next_cnt = r_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output decode (lamps depend on the state register only)
   // ------------------------------------------------------------------
   always_comb begin
      w_led_ns = c_LAMP_RED;
      w_led_we = c_LAMP_RED;
      case (r_state)
         S_NS_G:  w_led_ns = c_LAMP_GRN;
         S_NS_Y:  w_led_ns = c_LAMP_YEL;
         S_WE_G:  w_led_we = c_LAMP_GRN;
         S_WE_Y:  w_led_we = c_LAMP_YEL;
         default: begin
            w_led_ns = c_LAMP_RED;
            w_led_we = c_LAMP_RED;
         end
      endcase
      w_ack = sched.preempt &&
              (((r_state == S_NS_G) && !sched.preempt_dir) ||
               ((r_state == S_WE_G) &&  sched.preempt_dir));
   end

   assign sched.LED_NS      = w_led_ns;
   assign sched.LED_WE      = w_led_we;
   assign sched.phase       = r_state;
   assign sched.preempt_ack = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_scheduler
//  Description : Bench for traffic_phase_scheduler. A reference model tracks
//                which approach owns the right of way, whether it is in
//                green, yellow or clearance, and how long it has been there;
//                directed scenarios pin literal timings, then random demand,
//                pre-empt and reset traffic runs against the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_phase_scheduler;

   localparam int GMIN = 8;
   localparam int GMAX = 15;
   localparam int YEL  = 3;
   localparam int AR   = 2;

   localparam logic [1:0] K_GREEN = 2'd0;
   localparam logic [1:0] K_YEL   = 2'd1;
   localparam logic [1:0] K_CLEAR = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   traffic_phase_scheduler_if bus ();

   traffic_phase_scheduler #(
      .GREEN_MIN (GMIN),
      .GREEN_MAX (GMAX),
      .YELLOW    (YEL),
      .ALLRED    (AR),
      .CW        (5)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sched (bus.slave)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   // Model: owner = approach whose turn it is (0 NS, 1 WE), kind = what
   // that turn is doing, age = cycles spent in it so far.
   typedef struct packed {
      logic       owner;
      logic [1:0] kind;
      int         age;
   } mstate_t;

   mstate_t m;
   logic    m_valid = 1'b0;

   function automatic mstate_t model_next(mstate_t s, logic rn, logic rw,
                                          logic pe, logic pd);
      mstate_t n;
      logic    rx, ry;
      n     = s;
      n.age = s.age + 1;
      rx    = s.owner ? rw : rn;
      ry    = s.owner ? rn : rw;
      case (s.kind)
         K_GREEN: begin
            if (pe && pd == s.owner)            n.age = s.age + 1;
            else if (pe)                        begin n.kind = K_YEL; n.age = 0; end
            else if (s.age < GMIN - 1)          n.age = s.age + 1;
            else if (!ry)                       n.age = s.age + 1;
            else if (!rx || s.age >= GMAX - 1)  begin n.kind = K_YEL; n.age = 0; end
         end
         K_YEL: if (s.age == YEL - 1) begin n.kind = K_CLEAR; n.age = 0; end
         default: if (s.age == AR - 1) begin
            n.kind  = K_GREEN;
            n.age   = 0;
            n.owner = pe ? pd : ~s.owner;
         end
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m       <= '{owner: 1'b0, kind: K_GREEN, age: 0};
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m <= model_next(m, bus.req_ns, bus.req_we, bus.preempt, bus.preempt_dir);
      end
   end

   function automatic logic [2:0] lamp(logic [1:0] kind);
      return (kind == K_GREEN) ? 3'b001 : (kind == K_YEL) ? 3'b010 : 3'b100;
   endfunction

   task automatic check(string name, logic [2:0] got, logic [2:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
                    name, got, exp, cyc, $time);
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         logic [2:0] e_ph, e_ns, e_we;
         logic       e_ack;
         e_ph  = 3'(m.owner ? 3 : 0) + 3'(m.kind);
         e_ns  = m.owner ? 3'b100 : lamp(m.kind);
         e_we  = m.owner ? lamp(m.kind) : 3'b100;
         e_ack = bus.preempt && m.kind == K_GREEN && m.owner == bus.preempt_dir;
         check("phase",  bus.phase, e_ph);
         check("led_ns", bus.LED_NS, e_ns);
         check("led_we", bus.LED_WE, e_we);
         check("ack",    {2'b00, bus.preempt_ack}, {2'b00, e_ack});
         check("safety", {2'b00, (bus.LED_NS != 3'b100) && (bus.LED_WE != 3'b100)}, 3'd0);
      end
   end

   task automatic goto(int k);
      while (cyc < k) begin
         @(posedge clk);
         #2;
         cyc++;
      end
   endtask

   task automatic lit(string name, int k, logic [2:0] exp_ph, logic exp_ack);
      goto(k);
      @(negedge clk);
      check(name, bus.phase, exp_ph);
      check({name, "_ack"}, {2'b00, bus.preempt_ack}, {2'b00, exp_ack});
   endtask

   // Leaves the bench in cycle 0: the first cycle after the reset edge.
   task automatic do_reset(logic rn, logic rw);
      @(posedge clk);
      #2;
      rst             = 1'b0;
      bus.preempt     = 1'b0;
      bus.preempt_dir = 1'b0;
      @(posedge clk);
      #2;
      rst        = 1'b1;
      bus.req_ns = rn;
      bus.req_we = rw;
      cyc        = 0;
   endtask

   initial begin
      bus.req_ns      = 1'b0;
      bus.req_we      = 1'b0;
      bus.preempt     = 1'b0;
      bus.preempt_dir = 1'b0;

      // Idle: NS rests in green.
      do_reset(1'b0, 1'b0);
      lit("reset_phase", 0, 3'd0, 1'b0);
      @(negedge clk);
      check("reset_led_ns", bus.LED_NS, 3'b001);
      check("reset_led_we", bus.LED_WE, 3'b100);
      lit("idle_39", 39, 3'd0, 1'b0);

      // Single WE demand.
      do_reset(1'b0, 1'b1);
      lit("single_7",  7,  3'd0, 1'b0);
      lit("single_8",  8,  3'd1, 1'b0);
      lit("single_11", 11, 3'd2, 1'b0);
      lit("single_13", 13, 3'd3, 1'b0);
      lit("single_60", 60, 3'd3, 1'b0);

      // Max-out with both approaches requesting.
      do_reset(1'b1, 1'b1);
      lit("max_14", 14, 3'd0, 1'b0);
      lit("max_15", 15, 3'd1, 1'b0);
      lit("max_18", 18, 3'd2, 1'b0);
      lit("max_20", 20, 3'd3, 1'b0);
      lit("max_34", 34, 3'd3, 1'b0);
      lit("max_35", 35, 3'd4, 1'b0);
      lit("max_38", 38, 3'd5, 1'b0);
      lit("max_40", 40, 3'd0, 1'b0);

      // Opposing pre-empt during NS green.
      do_reset(1'b1, 1'b0);
      goto(2);
      bus.preempt     = 1'b1;
      bus.preempt_dir = 1'b1;
      lit("pre_3",  3,  3'd1, 1'b0);
      lit("pre_6",  6,  3'd2, 1'b0);
      lit("pre_8",  8,  3'd3, 1'b1);
      lit("pre_28", 28, 3'd3, 1'b1);
      goto(30);
      bus.preempt = 1'b0;
      lit("pre_31", 31, 3'd4, 1'b0);

      // Pre-empt in clearance returns green to NS.
      do_reset(1'b0, 1'b1);
      goto(11);
      bus.preempt     = 1'b1;
      bus.preempt_dir = 1'b0;
      lit("clr_12", 12, 3'd2, 1'b0);
      lit("clr_13", 13, 3'd0, 1'b1);
      goto(14);
      bus.preempt = 1'b0;

      // Reset in the middle of NS yellow.
      do_reset(1'b0, 1'b1);
      goto(9);
      rst = 1'b0;
      goto(10);
      rst = 1'b1;
      lit("rsty_10", 10, 3'd0, 1'b0);
      lit("rsty_17", 17, 3'd0, 1'b0);
      lit("rsty_18", 18, 3'd1, 1'b0);

      // Random demand, pre-empt and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #2;
         cyc++;
         if ($urandom_range(7) == 0)   bus.req_ns      = ~bus.req_ns;
         if ($urandom_range(7) == 0)   bus.req_we      = ~bus.req_we;
         if ($urandom_range(39) == 0)  bus.preempt     = ~bus.preempt;
         if ($urandom_range(19) == 0)  bus.preempt_dir = ~bus.preempt_dir;
         rst = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Actuated scheduler for a two-approach intersection (North-South and West-East).
- Decides which approach holds green, and for how long, from vehicle-presence requests and an emergency pre-empt input.
- Drives the same LED code per approach as the existing fixed-time light: 100 = red, 010 = yellow, 001 = green.
- Sits between the sensor and pre-empt inputs and the LED drivers. It replaces the fixed-time sequencing with demand-driven arbitration.

Parameters:
- GREEN_MIN, 8: minimum green duration in cycles; must be at least 1.
- GREEN_MAX, 15: maximum green duration in cycles when the opposing approach is requesting; must be at least GREEN_MIN.
- YELLOW, 3: yellow duration in cycles; must be at least 1.
- ALLRED, 2: all-red clearance duration in cycles; must be at least 1.
- CW, 5: width of the phase counter; all durations must be below 2^CW.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- req_ns, input, 1: NS vehicle presence, level-sensitive.
- req_we, input, 1: WE vehicle presence, level-sensitive.
- preempt, input, 1: emergency pre-empt request, level-sensitive.
- preempt_dir, input, 1: pre-empt target approach; 0 = NS, 1 = WE. Qualified by preempt.
- LED_NS, output, 3: NS lamp code.
- LED_WE, output, 3: WE lamp code.
- phase, output, 3: current state encoding, for observability.
- preempt_ack, output, 1: high while preempt=1 and the pre-empt target approach is green.

Behaviour:
- States and phase codes:
  - NS_G = 0
  - NS_Y = 1
  - RED_A = 2 (all-red after NS)
  - WE_G = 3
  - WE_Y = 4
  - RED_B = 5 (all-red after WE)
  - Codes 6 and 7 are unused; if reached, the next edge goes to NS_G with cnt=0.
- Outputs are a Moore decode of the state register only:
  - NS_G: LED_NS=001, LED_WE=100
  - NS_Y: LED_NS=010, LED_WE=100
  - RED_A and RED_B: both 100
  - WE_G: LED_NS=100, LED_WE=001
  - WE_Y: LED_NS=100, LED_WE=010
- Reset (rst=0 at an edge): state=NS_G, cnt=0. The cycle after the edge shows LED_NS=001, LED_WE=100, phase=0, preempt_ack=0. Reset applied mid-phase, including yellow or all-red, takes effect at that edge with no clearance.
- Phase counter cnt:
  - Set to 0 on every state entry; cnt=0 in the first cycle of a state.
  - Increments each cycle the state holds.
  - In green states it saturates at GREEN_MAX-1.
- Yellow states: move to the following all-red state when cnt==YELLOW-1, so yellow lasts exactly YELLOW cycles. Inputs are ignored.
- All-red states: when cnt==ALLRED-1, move to a green state, so all-red lasts exactly ALLRED cycles. Target green, in priority order:
  - if preempt=1, the green of preempt_dir;
  - else RED_A goes to WE_G and RED_B goes to NS_G.
  - A pre-empt can therefore return green to the same approach.
- Green state, own approach X, opposing approach Y. Evaluate in priority order, once per cycle:
  1. preempt=1 and preempt_dir=X: hold green. GREEN_MAX and opposing requests are ignored.
  2. preempt=1 and preempt_dir=Y: go to X yellow at the next edge, regardless of GREEN_MIN.
  3. cnt < GREEN_MIN-1: hold.
  4. req_Y=0: hold. Green rests indefinitely with no opposing demand.
  5. req_X=0 or cnt==GREEN_MAX-1: go to X yellow.
  6. Otherwise hold (gap extension while both approaches request).
- Simultaneous events:
  - Pre-empt outranks min/max timing in green only. It never shortens yellow or all-red.
  - Requests and pre-empt changing in the same cycle are evaluated together using the rules above.
- No configuration yields both approaches non-red at once. Every green-to-green change passes through YELLOW plus ALLRED cycles.

Test Plan (defaults; cycle 0 = first cycle after rst deasserts):
1. Idle: no requests, 40 cycles -> LED_NS=001, LED_WE=100 throughout; phase=0.
2. Single demand: req_we=1 from cycle 0, req_ns=0 -> NS green cycles 0-7, NS yellow 8-10, all-red 11-12, WE green from 13; WE green rests while req_ns=0.
3. Max-out: req_ns=req_we=1 held -> NS green 0-14, yellow 15-17, red 18-19, WE green 20-34, yellow 35-37, red 38-39, NS green at 40.
4. Opposing pre-empt: preempt=1, preempt_dir=1 at cycle 2 of NS green -> NS yellow cycles 3-5, red 6-7, WE green at 8 with preempt_ack=1. Green holds past 15 cycles with req_ns=1 while preempt=1; drops after preempt release once the normal rules are met.
5. Pre-empt during clearance: in RED_A, assert preempt=1, preempt_dir=0 -> the next green is NS_G, not WE_G; preempt_ack=1.
6. Reset mid-yellow: rst=0 for one edge during NS_Y cycle 1 -> next cycle NS_G, cnt=0, LED_NS=001. The full GREEN_MIN applies afterwards.
